// File: rtl/ifu_axi_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// States, AXI response codes and the NOP encoding used when a fetch times out.
package ifu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        OUT,
        WAIT_PC
    } ifu_state_e;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/ifu_axi_fetch_if.sv
// AXI4-Lite read channel, IDU handshake and write-back next-PC bundle of the IFU.
// master = fetch unit side, slave = memory/IDU/WBU side.
interface ifu_axi_fetch_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_err;
    logic              inst_valid;
    logic              inst_ready;
    logic              npc_valid;
    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] pc;

    modport master (
        output araddr, arvalid, rready, inst, inst_pc, inst_err, inst_valid, pc,
        input  arready, rdata, rresp, rvalid, inst_ready, npc_valid, npc
    );

    modport slave (
        input  araddr, arvalid, rready, inst, inst_pc, inst_err, inst_valid, pc,
        output arready, rdata, rresp, rvalid, inst_ready, npc_valid, npc
    );
endinterface

// File: rtl/ifu_axi_fetch.sv
// Multicycle instruction fetch: one AXI4-Lite read per retired instruction.
// Optional R-channel timeout enabled by defining IFU_FETCH_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | one cycle after reset before the first fetch
// AR      | read address presented, waiting for arready
// R       | waiting for the read beat
// OUT     | instruction presented to the IDU
// WAIT_PC | waiting for the next PC from write-back
module ifu_axi_fetch
    import ifu_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = 32'h8000_0000,
    parameter int                TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    ifu_axi_fetch_if.master    bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] inst_pc_q;
    logic              inst_err_q;
    logic              take_beat;
    logic              timeout_hit;

`ifdef IFU_FETCH_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Cleared on the AR handshake so each R phase starts counting from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state_q == AR && bus.arready) begin
            tmo_cnt <= '0;
        end else if (state_q == R && !bus.rvalid) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign timeout_hit = (state_q == R) && !bus.rvalid && (tmo_cnt == TMO_LAST);
`else
    logic unused_tmo;
    assign unused_tmo  = ^TMO_LAST;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        take_beat = 1'b0;
        case (state_q)
            IDLE:    state_d = AR;
            AR:      if (bus.arready) state_d = R;
            R: begin
                if (bus.rvalid) begin
                    take_beat = 1'b1;
                    state_d   = OUT;
                end else if (timeout_hit) begin
                    state_d   = OUT;
                end
            end
            OUT:     if (bus.inst_ready) state_d = WAIT_PC;
            WAIT_PC: if (bus.npc_valid) state_d = AR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            inst_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == WAIT_PC && bus.npc_valid) begin
                pc_q <= bus.npc;
            end
            if (take_beat) begin
                inst_q     <= bus.rdata;
                inst_pc_q  <= pc_q;
                inst_err_q <= (bus.rresp != RESP_OKAY);
            end else if (timeout_hit) begin
`ifdef IFU_FETCH_TIMEOUT_EN
                inst_q     <= NOP_INST;
`endif
                inst_pc_q  <= pc_q;
                inst_err_q <= 1'b1;
            end
        end
    end

    assign bus.araddr     = pc_q;
    assign bus.arvalid    = (state_q == AR);
    assign bus.rready     = (state_q == R);
    assign bus.inst_valid = (state_q == OUT);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_err   = inst_err_q;
    assign bus.pc         = pc_q;

endmodule
